// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   div_state_e    : controller state encoding (IDLE / ITER / FIX / DONE)
//   RES_READY      : value of out_valid while a result is presented
//   RES_NOT_READY  : value of out_valid when no result is presented
//   div_min()      : most-negative two's complement value for a given width,
//                    returned zero-extended to MAX_W bits (caller truncates)
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    localparam logic RES_READY     = 1'b1;
    localparam logic RES_NOT_READY = 1'b0;

    // Widest operand the MIN helper can describe.
    localparam int MAX_W = 128;

    function automatic logic [MAX_W-1:0] div_min(input int w);
        div_min = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   rem      : partial remainder (always < dvs on entry)
//   quo      : quotient shift register; its MSB is the next dividend bit
//   dvs      : divisor magnitude
//   rem_next : partial remainder after the trial subtraction
//   quo_next : quotient register shifted left with the new quotient bit
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   trial_s;
    logic [WIDTH+1:0] diff_s;

    // Trial subtract; the extra top bit of diff_s is the borrow.
    // Because rem < dvs, both kept values fit back into WIDTH bits.
    always_comb begin
        trial_s = {rem, quo[WIDTH-1]};
        diff_s  = {1'b0, trial_s} - {2'b00, dvs};
        if (diff_s[WIDTH+1]) begin
            rem_next = trial_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = diff_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider with valid/ready handshakes, tag passthrough
// and RISC-V M-extension corner cases (divide-by-zero, signed overflow).
// Quotient and remainder are delivered together.
//
// Ports:
//   ck_i, rs_i                 clock, synchronous active-high reset
//   in_valid_i / in_ready_o    request handshake
//   signed_i, dividend_i, divisor_i, tag_i   request payload (sampled at accept)
//   flush_i                    abort whatever is in flight, drop any result
//   out_valid_o / out_ready_i  result handshake (backpressure supported)
//   quot_o, rem_o, tag_o       registered result
//
// Build option: DIV_ITER_EARLY_OUT_EN -- when defined, divide-by-zero, signed
// overflow and |dividend| < |divisor| skip the iteration and return after
// two cycles. When undefined every operation takes WIDTH+1 cycles.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             ck_i,
    input  logic             rs_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int               CW        = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_V     = WIDTH'(div_min(WIDTH));
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

    div_state_e       state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] quo_r, rem_r, dvs_r, dvd_r;
    logic             neg_dd_r, neg_dv_r, dz_r, ovf_r;
    logic             hold_r;
    logic [TAG_W-1:0] tag_r;
    logic             in_ready_r, out_valid_r;
    logic [WIDTH-1:0] quot_out_r, rem_out_r;
    logic [TAG_W-1:0] tag_out_r;

    logic             neg_dd_s, neg_dv_s, dz_s, ovf_s, early_s, accept_s;
    logic [WIDTH-1:0] abs_dd_s, abs_dv_s;
    logic [WIDTH-1:0] step_quo_s, step_rem_s;
    logic [WIDTH-1:0] fix_q_s, fix_r_s;

    // Operand conditioning at accept: magnitudes, sign flags, corner cases.
    always_comb begin
        neg_dd_s = signed_i & dividend_i[WIDTH-1];
        neg_dv_s = signed_i & divisor_i[WIDTH-1];
        if (neg_dd_s) begin
            abs_dd_s = {WIDTH{1'b0}} - dividend_i;
        end else begin
            abs_dd_s = dividend_i;
        end
        if (neg_dv_s) begin
            abs_dv_s = {WIDTH{1'b0}} - divisor_i;
        end else begin
            abs_dv_s = divisor_i;
        end
        dz_s  = (divisor_i == {WIDTH{1'b0}});
        ovf_s = signed_i & (dividend_i == MIN_V) & (divisor_i == {WIDTH{1'b1}});
`ifdef DIV_ITER_EARLY_OUT_EN
        early_s = dz_s | ovf_s | (abs_dd_s < abs_dv_s);
`else
        early_s = 1'b0;
`endif
        accept_s = in_valid_i & in_ready_r & ~flush_i;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .dvs      (dvs_r),
        .rem_next (step_rem_s),
        .quo_next (step_quo_s)
    );

    // Final result: forced corner cases, otherwise sign-corrected magnitudes.
    // dvd_r holds the original dividend, which is the divide-by-zero remainder.
    always_comb begin
        if (dz_r) begin
            fix_q_s = {WIDTH{1'b1}};
            fix_r_s = dvd_r;
        end else if (ovf_r) begin
            fix_q_s = MIN_V;
            fix_r_s = {WIDTH{1'b0}};
        end else begin
            if (neg_dd_r ^ neg_dv_r) begin
                fix_q_s = {WIDTH{1'b0}} - quo_r;
            end else begin
                fix_q_s = quo_r;
            end
            if (neg_dd_r) begin
                fix_r_s = {WIDTH{1'b0}} - rem_r;
            end else begin
                fix_r_s = rem_r;
            end
        end
    end

    // Controller and datapath registers; flush beats every handshake.
    always_ff @(posedge ck_i) begin
        if (rs_i) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            neg_dd_r    <= 1'b0;
            neg_dv_r    <= 1'b0;
            dz_r        <= 1'b0;
            ovf_r       <= 1'b0;
            hold_r      <= 1'b0;
            tag_r       <= {TAG_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= RES_NOT_READY;
            quot_out_r  <= {WIDTH{1'b0}};
            rem_out_r   <= {WIDTH{1'b0}};
            tag_out_r   <= {TAG_W{1'b0}};
        end else if (flush_i) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= RES_NOT_READY;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r    <= ST_ITER;
                        in_ready_r <= 1'b0;
                        dvs_r      <= abs_dv_s;
                        dvd_r      <= dividend_i;
                        neg_dd_r   <= neg_dd_s;
                        neg_dv_r   <= neg_dv_s;
                        dz_r       <= dz_s;
                        ovf_r      <= ovf_s;
                        tag_r      <= tag_i;
                        hold_r     <= early_s;
                        if (early_s) begin
                            // Single settle cycle in ITER, then FIX with
                            // the trivial raw result quot=0, rem=|dividend|.
                            cnt_r <= LAST_STEP;
                            quo_r <= {WIDTH{1'b0}};
                            rem_r <= abs_dd_s;
                        end else begin
                            cnt_r <= {CW{1'b0}};
                            quo_r <= abs_dd_s;
                            rem_r <= {WIDTH{1'b0}};
                        end
                    end
                end
                ST_ITER: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (!hold_r) begin
                        quo_r <= step_quo_s;
                        rem_r <= step_rem_s;
                    end
                    if (cnt_r == LAST_STEP) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    quot_out_r  <= fix_q_s;
                    rem_out_r   <= fix_r_s;
                    tag_out_r   <= tag_r;
                    out_valid_r <= RES_READY;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_r <= RES_NOT_READY;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= RES_NOT_READY;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign quot_o      = quot_out_r;
    assign rem_o       = rem_out_r;
    assign tag_o       = tag_out_r;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter (WIDTH=32, TAG_W=4): directed corner
// cases plus randomized operations against an arithmetic reference model.
module tb_div_iter;

    localparam int W  = 32;
    localparam int TW = 4;

    logic          ck_i = 1'b0;
    logic          rs_i = 1'b1;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic          signed_i = 1'b0;
    logic [W-1:0]  dividend_i = 32'd0;
    logic [W-1:0]  divisor_i = 32'd0;
    logic [TW-1:0] tag_i = 4'd0;
    logic          flush_i = 1'b0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [W-1:0]  quot_o;
    logic [W-1:0]  rem_o;
    logic [TW-1:0] tag_o;

    int n_cmp = 0;
    int n_bad = 0;

    div_iter #(.WIDTH(W), .TAG_W(TW)) dut (
        .ck_i        (ck_i),
        .rs_i        (rs_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .tag_i       (tag_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .quot_o      (quot_o),
        .rem_o       (rem_o),
        .tag_o       (tag_o)
    );

    always #5 ck_i = ~ck_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M semantics from plain arithmetic, plus expected latency.
    function automatic void ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output int lat);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        ma;
        logic [31:0]        mb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = sg && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (ovf) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sg) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        ma  = (sg && sa < 0) ? 32'd0 - a : a;
        mb  = (sg && sb < 0) ? 32'd0 - b : b;
        lat = W + 1;
`ifdef DIV_ITER_EARLY_OUT_EN
        if (b == 32'd0 || ovf || ma < mb) lat = 2;
`else
        if (ma < mb) lat = W + 1;
`endif
    endfunction

    task automatic do_reset();
        rs_i = 1'b1;
        repeat (2) @(posedge ck_i);
        #1;
        rs_i = 1'b0;
    endtask

    // Full transaction: accept, wait for result, optional stall, consume.
    task automatic run_op(input string nm, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tg, input int stall);
        logic [31:0] eq;
        logic [31:0] er;
        int          elat;
        int          cyc;
        bit          seen;
        ref_div(sg, a, b, eq, er, elat);
        check_val({nm, "_in_ready"}, {63'd0, in_ready_o}, 64'd1);
        in_valid_i = 1'b1;
        signed_i   = sg;
        dividend_i = a;
        divisor_i  = b;
        tag_i      = tg;
        @(posedge ck_i);
        #1;
        in_valid_i = 1'b0;
        // Operands must be ignored after accept.
        dividend_i = $urandom;
        divisor_i  = $urandom;
        signed_i   = ~sg;
        tag_i      = 4'($urandom);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge ck_i);
            #1;
            cyc++;
            if (out_valid_o) seen = 1'b1;
        end
        check_val({nm, "_latency"}, 64'(cyc), 64'(elat));
        check_val({nm, "_quot"}, {32'd0, quot_o}, {32'd0, eq});
        check_val({nm, "_rem"}, {32'd0, rem_o}, {32'd0, er});
        check_val({nm, "_tag"}, {60'd0, tag_o}, {60'd0, tg});
        for (int i = 0; i < stall; i++) begin
            @(posedge ck_i);
            #1;
            check_val({nm, "_stall_valid"}, {63'd0, out_valid_o}, 64'd1);
            check_val({nm, "_stall_quot"}, {32'd0, quot_o}, {32'd0, eq});
            check_val({nm, "_stall_rem"}, {32'd0, rem_o}, {32'd0, er});
            check_val({nm, "_stall_in_ready"}, {63'd0, in_ready_o}, 64'd0);
        end
        out_ready_i = 1'b1;
        @(posedge ck_i);
        #1;
        out_ready_i = 1'b0;
        check_val({nm, "_consumed_valid"}, {63'd0, out_valid_o}, 64'd0);
        check_val({nm, "_consumed_in_ready"}, {63'd0, in_ready_o}, 64'd1);
    endtask

    // Start an operation, abort it after 'steps' cycles by flush or reset.
    task automatic abort_op(input string nm, input bit use_reset, input int steps);
        bit seen;
        in_valid_i = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        tag_i      = 4'd5;
        @(posedge ck_i);
        #1;
        in_valid_i = 1'b0;
        repeat (steps - 1) @(posedge ck_i);
        #1;
        if (use_reset) rs_i = 1'b1;
        else           flush_i = 1'b1;
        @(posedge ck_i);
        #1;
        rs_i    = 1'b0;
        flush_i = 1'b0;
        check_val({nm, "_valid"}, {63'd0, out_valid_o}, 64'd0);
        check_val({nm, "_in_ready"}, {63'd0, in_ready_o}, 64'd1);
        if (use_reset) begin
            check_val({nm, "_quot_cleared"}, {32'd0, quot_o}, 64'd0);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge ck_i);
            #1;
            if (out_valid_o) seen = 1'b1;
        end
        check_val({nm, "_no_result"}, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        bit          seen;

        do_reset();
        check_val("reset_valid", {63'd0, out_valid_o}, 64'd0);
        check_val("reset_quot", {32'd0, quot_o}, 64'd0);
        check_val("reset_rem", {32'd0, rem_o}, 64'd0);
        check_val("reset_tag", {60'd0, tag_o}, 64'd0);
        check_val("reset_in_ready", {63'd0, in_ready_o}, 64'd1);

        run_op("u100_7", 1'b0, 32'd100, 32'd7, 4'd3, 0);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 4'd1, 0);
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 4'd2, 0);
        run_op("dz_s", 1'b1, 32'h0000_1234, 32'd0, 4'd4, 0);
        run_op("dz_u", 1'b0, 32'h0000_1234, 32'd0, 4'd6, 0);
        run_op("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 0);
        run_op("min_div_1", 1'b1, 32'h8000_0000, 32'd1, 4'd8, 0);
        run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd9, 0);
        run_op("small_3_10", 1'b0, 32'd3, 32'd10, 4'd10, 0);
        run_op("s_small_neg", 1'b1, 32'hFFFF_FFFD, 32'd10, 4'd11, 0);
        run_op("backpressure", 1'b0, 32'd12345, 32'd17, 4'd12, 5);

        abort_op("flush_step10", 1'b0, 10);
        abort_op("reset_step20", 1'b1, 20);

        // Flush together with a request in IDLE: nothing may be accepted.
        in_valid_i = 1'b1;
        flush_i    = 1'b1;
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        @(posedge ck_i);
        #1;
        in_valid_i = 1'b0;
        flush_i    = 1'b0;
        check_val("flush_accept_in_ready", {63'd0, in_ready_o}, 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge ck_i);
            #1;
            if (out_valid_o) seen = 1'b1;
        end
        check_val("flush_accept_no_result", {63'd0, seen}, 64'd0);

        for (int k = 0; k < 30; k++) begin
            sg = 1'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       begin sg = 1'b1; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                3:       begin a = 32'($urandom_range(0, 255)); b = $urandom; end
                4:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            run_op("rand", sg, a, b, 4'($urandom), k % 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Parametrised iterative restoring divider for the EX stage.
- Generalised successor of the fixed 32-bit divider:
  - WIDTH-bit operands.
  - valid/ready handshake on input and output, with output backpressure.
  - Tag passthrough.
  - RISC-V M-extension corner-case semantics: divide-by-zero and signed overflow.
- Delivers quotient and remainder together; EX selects DIV/REM.

Parameters:
- WIDTH, 32, operand/result width (>=2).
- TAG_W, 4, width of opaque tag carried from request to result.

Ports:
- ck_i  in  1  clock.
- rs_i  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  divider can accept request.
- signed_i  in  1  1 = signed (two's complement) operation.
- dividend_i  in  WIDTH  dividend.
- divisor_i  in  WIDTH  divisor.
- tag_i  in  TAG_W  request tag.
- flush_i  in  1  abort any operation (exception/interrupt).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- quot_o  out  WIDTH  quotient.
- rem_o  out  WIDTH  remainder.
- tag_o  out  TAG_W  tag of the result.

Behaviour:
- Reset (rs_i high at posedge): state IDLE; out_valid_o=0; quot_o=0; rem_o=0; tag_o=0; counter=0. Reset mid-operation discards the operation. in_ready_o=1 from the first cycle after reset.
- States:
  - IDLE: in_ready_o=1. Request accepted on in_valid_i && in_ready_o && !flush_i.
    - Latch signed_i, tag_i and sign bits.
    - Latch |dividend| and |divisor| (magnitudes only when signed_i=1).
    - Set flags dz = (divisor==0) and ovf = signed_i && dividend==MIN && divisor==all-ones.
    - Counter=0. Go to ITER.
  - ITER: one restoring step per cycle.
    - Trial subtract of the (WIDTH+1)-bit partial remainder minus {0,divisor}.
    - On no borrow: keep the difference and shift quotient bit 1.
    - On borrow: keep the partial remainder and shift 0.
    - Counter increments. After WIDTH steps go to FIX.
  - FIX: one cycle. Loads quot_o/rem_o/tag_o, sets out_valid_o=1, goes to DONE.
    - dz: quot = all-ones, rem = original dividend. Signed and unsigned alike.
    - ovf: quot = MIN (1 followed by zeros), rem = 0.
    - Otherwise: quotient negated iff signed && sign(dividend)^sign(divisor). Remainder negated iff signed && sign(dividend). Truncating division: remainder takes the dividend's sign.
  - DONE: outputs held stable while out_valid_o && !out_ready_i. On out_ready_i: out_valid_o=0 and go to IDLE. No new accept in the same cycle.
- Latency: accept edge to out_valid_o high = WIDTH+1 cycles (33 for WIDTH=32). Throughput is one operation per WIDTH+3 cycles minimum.
- flush_i: in any state the next edge goes to IDLE, out_valid_o=0, and the result is dropped.
  - flush_i takes priority over in_valid_i and over out_ready_i in the same cycle.
  - A flush in DONE discards an unconsumed result.
- Inputs are sampled only at accept; later changes to dividend_i/divisor_i/signed_i have no effect.
- WIDTH arithmetic: all magnitudes are WIDTH bits. MIN magnitude fits because the ovf case bypasses the datapath, and MIN/1 negates back correctly modulo 2^WIDTH.

Optional Feature:
- Macro: DIV_ITER_EARLY_OUT_EN.
- Defined: at accept, if dz, ovf, or |dividend| < |divisor|, skip ITER and go directly to FIX. Latency is 2 cycles.
  - In the third case the raw result is quot=0, rem=|dividend|, then sign-fixed as above.
- Undefined: every operation takes the full WIDTH+1 latency. dz/ovf results are still forced in FIX.

Decomposition:
- Shared package div_pkg holds:
  - the state encoding (IDLE/ITER/FIX/DONE);
  - the result-ready/not-ready constants;
  - a function for the MIN constant.
- One natural sub-module: div_step, a combinational single restoring step parametrised by WIDTH. Inputs: partial remainder, quotient shift register, divisor. Outputs: next values. Used by ITER.

Test Plan:
- Unsigned 100/7, tag 3 -> quot=14, rem=2, tag_o=3; out_valid_o exactly 33 cycles after accept.
- Signed 0xFFFFFFF9 (-7) / 2 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF. Signed 7/0xFFFFFFFE -> quot=0xFFFFFFFD, rem=1.
- Divide 0x1234/0, signed and unsigned -> quot=0xFFFFFFFF, rem=0x1234. Signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0.
- Hold out_ready_i low 5 cycles after out_valid_o -> outputs stable, in_ready_o=0; accepted on the 6th cycle, in_ready_o=1 the following cycle.
- flush_i at ITER step 10, and rs_i at step 20 of a second op -> IDLE next cycle, no out_valid_o. flush_i together with in_valid_i in IDLE -> no accept.
- With DIV_ITER_EARLY_OUT_EN: 3/10 -> quot=0, rem=3 with latency 2. Without it -> same result, latency 33.
